// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one iteration per clock, with sign correction applied in a final cycle.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ITER_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  kill,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] operandA,
   input  logic [DATA_WIDTH-1:0] operandB,
   input  logic [4:0]            desRegisterIn,
   output logic                  busy,
   output logic                  resultValid,
   output logic [DATA_WIDTH-1:0] result,
   output logic [4:0]            desRegister
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t state, state_next;

   logic [ITER_BITS-1:0] count;
   logic [2:0]           op;
   logic [4:0]           rd;
   logic                 neg_a, neg_b;
   logic                 special;
   logic [W-1:0]         special_value;
   logic [W-1:0]         addend;
   logic [2*W-1:0]       acc;

   logic         accept, a_signed, b_signed, div_zero, overflow, fast;
   logic [W-1:0] abs_a, abs_b, special_next;
   logic [W:0]   mul_sum, div_shifted;
   logic         div_ge;
   logic [W-1:0] div_sub;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0] quo_fix, rem_fix, final_value;

   assign busy = (state != IDLE);
   assign accept = (state == IDLE) && start && !kill;

   // Operand decode at the start edge: signedness, magnitudes and fast-path results
   always_comb begin
      a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      abs_a    = (a_signed && operandA[W-1]) ? -operandA : operandA;
      abs_b    = (b_signed && operandB[W-1]) ? -operandB : operandB;
      div_zero = funct3[2] && (operandB == '0);
      overflow = ((funct3 == 3'b100) || (funct3 == 3'b110)) && (operandA == MIN_NEG) && (operandB == '1);
      fast     = div_zero || overflow;
      if (div_zero)
         special_next = funct3[1] ? operandA : '1;
      else
         special_next = funct3[1] ? '0 : MIN_NEG;
   end

   // One iteration of each algorithm; acc holds {product} or {remainder, quotient}
   always_comb begin
      mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, addend} : '0);
      div_shifted = {acc[2*W-1:W], acc[W-1]};
      div_ge      = div_shifted >= {1'b0, addend};
      div_sub     = div_shifted[W-1:0] - addend;
   end

   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? -acc : acc;
      quo_fix  = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
      rem_fix  = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (special)
         final_value = special_value;
      else if (op[2])
         final_value = op[1] ? rem_fix : quo_fix;
      else if (op == 3'b000)
         final_value = prod_fix[W-1:0];
      else
         final_value = prod_fix[2*W-1:W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = fast ? FINISH : CALC;
         CALC:    if (kill) state_next = IDLE;
                  else if (count == '0) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count         <= '0;
         op            <= '0;
         rd            <= '0;
         neg_a         <= 1'b0;
         neg_b         <= 1'b0;
         special       <= 1'b0;
         special_value <= '0;
         addend        <= '0;
         acc           <= '0;
         result        <= '0;
         desRegister   <= '0;
         resultValid   <= 1'b0;
      end else begin
         resultValid <= 1'b0;
         if (accept) begin
            op            <= funct3;
            rd            <= desRegisterIn;
            neg_a         <= a_signed && operandA[W-1];
            neg_b         <= b_signed && operandB[W-1];
            special       <= fast;
            special_value <= special_next;
            count         <= ITER_BITS'(W-1);
            addend        <= funct3[2] ? abs_b : abs_a;
            acc           <= {{W{1'b0}}, funct3[2] ? abs_a : abs_b};
         end else if (state == CALC && !kill) begin
            if (op[2])
               acc <= div_ge ? {div_sub, acc[W-2:0], 1'b1} : {div_shifted[W-1:0], acc[W-2:0], 1'b0};
            else
               acc <= {mul_sum, acc[W-1:1]};
            if (count != '0)
               count <= count - 1'b1;
         end else if (state == FINISH && !kill) begin
            result      <= final_value;
            desRegister <= rd;
            resultValid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit that sits directly downstream of the register file.
- It consumes readData1/readData2 as operands and produces a result plus destination index, which the writeback mux drives into writeData/desRegister with writeEnable.
- It stalls the core via busy for the duration of the operation.
- It uses radix-2 shift-add multiplication and restoring division, one iteration per clock.

Parameters:
- DATA_WIDTH, 32, operand/result width (RV32)
- ITER_BITS, 5, iteration counter width (log2 DATA_WIDTH)

Ports:
- clk  input  1  core clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- kill  input  1  abort current operation (pipeline flush)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operandA  input  DATA_WIDTH  rs1 value (readData1)
- operandB  input  DATA_WIDTH  rs2 value (readData2)
- desRegisterIn  input  5  rd index captured with operands
- busy  output  1  high while an operation is in flight
- resultValid  output  1  one-cycle pulse; used as register-file writeEnable
- result  output  DATA_WIDTH  final value; held until next resultValid
- desRegister  output  5  rd of the completed operation; held with result

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy=0, resultValid=0, result=0, desRegister=0.
  - All internal accumulators and the counter are cleared.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On an edge with start=1 and kill=0: latch funct3, desRegisterIn, and absolute-value operands per signedness, plus the sign flags.
  - Then go to CALC with count=DATA_WIDTH-1.
  - start=0 keeps the unit in IDLE.
- Signedness of operands:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Fast path:
  - Divide by zero (B==0, any div/rem op) or signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) skips CALC and goes straight to FINISH on the start edge.
- CALC, one iteration per edge:
  - Multiply: 64-bit product register, shift-add.
  - Divide: 32-bit partial remainder plus quotient shift, restoring subtract.
  - When count==0, the final iteration executes and the state moves to FINISH; otherwise count decrements.
- FINISH (one edge):
  - Apply sign correction: negate the product if signs differ; quotient negative if signs differ; remainder takes the sign of the dividend.
  - Select the word to return: low 32 bits for MUL, high 32 bits for MULH/MULHSU/MULHU.
  - Register result and desRegister, pulse resultValid=1 for exactly one cycle, return to IDLE.
- Special results:
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → operandA.
  - DIV overflow → 0x80000000.
  - REM overflow → 0.
- Latency, with E0 = the start edge:
  - Normal operation: resultValid high in the cycle after edge E0+33.
  - Fast path: resultValid high in the cycle after E0+1.
- busy:
  - busy=1 whenever state≠IDLE, i.e. from after E0 up to and including the FINISH edge.
  - busy=0 in the resultValid cycle.
  - A new start is accepted in the resultValid cycle (back-to-back allowed).
- start while busy: ignored, with no effect on the in-flight operation.
- kill:
  - With state≠IDLE, kill=1 at an edge → IDLE; no resultValid; result and desRegister keep their old values.
  - kill with start in IDLE → request not accepted.
  - kill in the same edge as FINISH → result is suppressed (kill wins).
- rd = x0: the result is still produced and resultValid still pulses; the register file discards writes to x0.
- Operand inputs are sampled only at the start edge; later changes are ignored.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), rd=5 → result 0xFFFFFFEB, desRegister 5, resultValid high exactly 34 cycles after start asserted; busy=1 for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; back-to-back starts with no idle gap.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; all with resultValid two cycles after start.
- Start DIVU, re-assert start with different operands at cycle 5 → ignored, original result returned; new op then kill at cycle 10 → no resultValid, busy=0 next cycle, previous result retained.
- Assert reset between clock edges at cycle 15 of a MUL → busy, resultValid, result, desRegister go to 0 immediately; after release, a new MUL 3×4 → 12.
